ram_req_ctrl: RTL and testbench

- Initiator-side controller that drives the single-port RAM macro (`we_i`/`address_i`/`data_i`/`data_o` port) on behalf of a host.
- Host side is a valid/ready request channel plus a valid/ready read-response channel.
- Memory side issues registered write strobes and addresses, then captures read data after a fixed RAM read latency.
- Also provides a hardware clear that zero-fills the whole RAM. Sits between the user-project logic and the `ram_5x32` instance.

---
 rtl/ram_ctrl_pkg.sv | 31 +++
 rtl/ram_req_ctrl_if.sv | 26 ++
 rtl/ram_clear_sequencer.sv | 39 +++
 rtl/ram_req_ctrl.sv | 148 ++++++++++++++
 tb/tb_ram_req_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM request controller and its clear sequencer.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    RSP       = 2'd2,
    CLEAR     = 2'd3
  } state_e;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_MEMORY_DEPTH  = 32;
  localparam int DEF_READ_LATENCY  = 1;

  localparam int READ_LATENCY_MIN  = 1;
  localparam int READ_LATENCY_MAX  = 3;
  localparam int LAT_CNT_W         = $clog2(READ_LATENCY_MAX + 1);

  // Out-of-range latencies are clamped so the countdown never under- or overflows.
  function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
    if (lat < READ_LATENCY_MIN) begin
      return LAT_CNT_W'(READ_LATENCY_MIN);
    end else if (lat > READ_LATENCY_MAX) begin
      return LAT_CNT_W'(READ_LATENCY_MAX);
    end else begin
      return LAT_CNT_W'(lat);
    end
  endfunction

endpackage

// File: rtl/ram_req_ctrl_if.sv
// Host-side request/response channel of the RAM controller; suffixes are from the controller's view.
interface ram_req_ctrl_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);

  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_we_i;
  logic [ADDRESS_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0]    req_wdata_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [DATA_WIDTH-1:0]    rsp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

endinterface

// File: rtl/ram_clear_sequencer.sv
// Address counter for the zero-fill sweep: restarts at 0, steps once per cycle, parks at the last word.
module ram_clear_sequencer #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int MEMORY_DEPTH  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     step_i,
  output logic [ADDRESS_WIDTH-1:0] addr_next_o,
  output logic                     last_o
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (start_i) begin
      addr_d = '0;
    end else if (step_i && (addr_q != LAST_ADDR)) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_next_o = addr_d;
  assign last_o      = (addr_q == LAST_ADDR);

endmodule

// File: rtl/ram_req_ctrl.sv
// Host-to-RAM controller: single-cycle writes, fixed-latency reads with a held response, and a zero-fill clear.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MEMORY_DEPTH  = DEF_MEMORY_DEPTH,
  parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  ram_req_ctrl_if.slave            host,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0]    mem_data_o,
  input  logic [DATA_WIDTH-1:0]    mem_data_i
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load(READ_LATENCY);

  state_e                   state_q, state_d;
  logic [LAT_CNT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]    mem_data_q, mem_data_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                     busy_q, busy_d;

  logic                     seq_start;
  logic                     seq_step;
  logic [ADDRESS_WIDTH-1:0] seq_addr_next;
  logic                     seq_last;

  ram_clear_sequencer #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .MEMORY_DEPTH  (MEMORY_DEPTH)
  ) u_clear_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (seq_start),
    .step_i      (seq_step),
    .addr_next_o (seq_addr_next),
    .last_o      (seq_last)
  );

  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    mem_we_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    seq_start     = 1'b0;
    seq_step      = 1'b0;

    case (state_q)
      IDLE: begin
        // A clear wins over a simultaneous request; the host keeps the request asserted.
        if (clear_i) begin
          state_d       = CLEAR;
          seq_start     = 1'b1;
          mem_we_d      = 1'b1;
          mem_address_d = seq_addr_next;
          mem_data_d    = '0;
        end else if (host.req_valid_i) begin
          mem_address_d = host.req_addr_i;
          if (host.req_we_i) begin
            mem_we_d   = 1'b1;
            mem_data_d = host.req_wdata_i;
          end else begin
            state_d   = READ_WAIT;
            lat_cnt_d = LAT_LOAD;
          end
        end
      end

      READ_WAIT: begin
        // The RAM output lags the address by READ_LATENCY; one extra cycle covers the address register.
        if (lat_cnt_q == '0) begin
          rsp_rdata_d = mem_data_i;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end

      RSP: begin
        if (host.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      CLEAR: begin
        if (seq_last) begin
          state_d = IDLE;
        end else begin
          seq_step      = 1'b1;
          mem_we_d      = 1'b1;
          mem_address_d = seq_addr_next;
          mem_data_d    = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      lat_cnt_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign host.req_ready_o = (state_q == IDLE);
  assign host.rsp_valid_o = rsp_valid_q;
  assign host.rsp_rdata_o = rsp_rdata_q;
  assign busy_o           = busy_q;
  assign mem_we_o         = mem_we_q;
  assign mem_address_o    = mem_address_q;
  assign mem_data_o       = mem_data_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Scoreboard bench for ram_req_ctrl driving a behavioural 32x32 RAM with one cycle of read latency.
module tb_ram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        busy;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int rsp_cnt  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ram_mem [0:31];

  always #5 clk = ~clk;

  ram_req_ctrl_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

  ram_req_ctrl #(
    .ADDRESS_WIDTH (5),
    .DATA_WIDTH    (32),
    .MEMORY_DEPTH  (32),
    .READ_LATENCY  (1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host          (bus),
    .clear_i       (clear),
    .busy_o        (busy),
    .mem_we_o      (mem_we),
    .mem_address_o (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_data_i    (mem_rdata)
  );

  // Registered-read RAM: a write lands at the edge, read data is the pre-edge contents.
  always @(posedge clk) begin
    if (mem_we === 1'b1) ram_mem[mem_addr] <= mem_wdata;
    mem_rdata <= ram_mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: counts strobes/responses and pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt++;
    if (bus.rsp_valid_o === 1'b1) rsp_cnt++;
    if (bus.rsp_valid_o === 1'b1 && bus.rsp_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", bus.rsp_rdata_o, 32'hFFFF_FFFF);
      end else begin
        check("rsp_data", bus.rsp_rdata_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = data;
    tick();
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] exp, input int hold);
    int lat;
    int bad;
    exp_q.push_back(exp);
    bus.rsp_ready_i = (hold == 0);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = addr;
    tick();
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (bus.rsp_valid_o !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("read_latency", lat, 3);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== exp || bus.req_ready_o !== 1'b0) bad++;
      tick();
    end
    if (hold > 0) begin
      check("bp_stable_cycles_bad", bad, 0);
      bus.rsp_ready_i = 1'b1;
    end
    tick();
    check("rsp_done_valid", bus.rsp_valid_o, 0);
    check("rsp_done_ready", bus.req_ready_o, 1);
  endtask

  initial begin
    int we_base;
    int rsp_base;
    int busy_cyc;
    int sweep_bad;
    int guard;

    // Reset held with a live write request: nothing may reach the RAM.
    rst             = 1'b1;
    clear           = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 5'd5;
    bus.req_wdata_i = 32'h1234_5678;
    bus.rsp_ready_i = 1'b1;
    repeat (3) tick();
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_wdata, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    check("rst_busy", busy, 0);
    check("rst_we_pulses", we_cnt, 0);
    rst             = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    check("post_rst_ready", bus.req_ready_o, 1);
    check("post_rst_busy", busy, 0);
    tick();

    // Write/read round trip.
    do_write(5'd5, 32'hDEAD_BEEF);
    check("wr_strobe", {mem_we, 26'd0, mem_addr}, {1'b1, 26'd0, 5'd5});
    check("wr_data", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("wr_strobe_single", mem_we, 0);
    do_read(5'd5, 32'hDEAD_BEEF, 0);

    // Back-to-back writes followed immediately by read-after-write.
    we_base = we_cnt;
    for (int i = 0; i < 4; i++) begin
      do_write(5'(i), 32'h1111_1111 * (i + 1));
      check("b2b_we", mem_we, 1);
      check("b2b_addr", mem_addr, i);
    end
    do_read(5'd3, 32'h4444_4444, 0);
    check("b2b_we_count", we_cnt - we_base, 4);

    // Response backpressure for five cycles.
    do_write(5'd7, 32'h0707_A5A5);
    do_read(5'd7, 32'h0707_A5A5, 5);

    // Fill the whole RAM, then clear with a competing write request.
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'hC0DE_0000 | i);
    tick();
    we_base         = we_cnt;
    clear           = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 5'd3;
    bus.req_wdata_i = 32'hBAD0_0BAD;
    tick();
    clear           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    busy_cyc  = 0;
    sweep_bad = 0;
    while (busy === 1'b1 && busy_cyc < 64) begin
      if (mem_we !== 1'b1 || mem_addr !== 5'(busy_cyc) || mem_wdata !== 32'h0) sweep_bad++;
      busy_cyc++;
      tick();
    end
    check("clr_busy_cycles", busy_cyc, 32);
    check("clr_sweep_bad", sweep_bad, 0);
    check("clr_we_count", we_cnt - we_base, 32);
    check("clr_done_ready", bus.req_ready_o, 1);
    check("clr_done_we", mem_we, 0);
    do_read(5'd0, 32'h0, 0);
    do_read(5'd31, 32'h0, 0);
    do_read(5'd3, 32'h0, 0);

    // Reset during READ_WAIT abandons the read.
    do_write(5'd10, 32'hAAAA_000A);
    do_write(5'd31, 32'hAAAA_001F);
    do_write(5'd0, 32'hAAAA_0000);
    rsp_base        = rsp_cnt;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 5'd10;
    tick();
    bus.req_valid_i = 1'b0;
    check("rw_in_wait_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_rst_we", mem_we, 0);
    check("rw_rst_busy", busy, 0);
    repeat (5) tick();
    check("rw_no_rsp", rsp_cnt - rsp_base, 0);

    // Reset during CLEAR just before address 10 is written.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    guard = 0;
    while (mem_addr !== 5'd9 && guard < 64) begin
      tick();
      guard++;
    end
    check("rc_reached_addr9", mem_addr, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rc_rst_we", mem_we, 0);
    check("rc_rst_busy", busy, 0);
    tick();
    do_read(5'd10, 32'hAAAA_000A, 0);
    do_read(5'd31, 32'hAAAA_001F, 0);
    do_read(5'd0, 32'h0, 0);

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
